// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if
//   Bundles the scan controller's mux-side and consumer-side signals.
//   Signals:
//     start  scan request (consumer -> controller)
//     Sel    2-bit mux select (controller -> mux)
//     F      mux output being scanned (mux -> controller)
//     Data   4 packed channel samples (controller -> consumer)
//     valid  Data holds a complete scan (controller -> consumer)
//     ready  consumer accepts Data on valid && ready
//     busy   controller is scanning or holding a result
//   Modports:
//     master  the scan controller
//     slave   the mux/consumer side
interface mux_scan_ctrl_if;
   logic       start;
   logic [1:0] Sel;
   logic       F;
   logic [3:0] Data;
   logic       valid;
   logic       ready;
   logic       busy;

   modport master (
      input  start, F, ready,
      output Sel, Data, valid, busy
   );

   modport slave (
      output start, F, ready,
      input  Sel, Data, valid, busy
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Steps a 4-to-1 mux select through channels 0..3, waits SETTLE cycles on
//   each, samples the mux output into Data[channel] and presents the 4-bit
//   word through a valid/ready handshake.
//   Parameters:
//     SETTLE  cycles per channel before sampling (1..15)
//   Ports:
//     clk  clock, rising edge
//     rst  synchronous active-high reset
//     bus  mux_scan_ctrl_if.master (start, Sel, F, Data, valid, ready, busy)
//   Build option:
//     MUX_SCAN_CONTINUOUS_EN  when defined, the handshake edge restarts the
//                             scan directly instead of returning to IDLE.
module mux_scan_ctrl #(
   parameter int unsigned SETTLE = 2
) (
   input logic             clk,
   input logic             rst,
   mux_scan_ctrl_if.master bus
);

   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("mux_scan_ctrl: SETTLE must be in 1..15");
   end

   localparam logic [3:0] LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_DONE
   } state_t;

   state_t     state;
   logic [1:0] sel;
   logic [3:0] cnt;
   logic [3:0] data;
   logic       valid;
   logic       busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         sel   <= '0;
         cnt   <= '0;
         data  <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state <= ST_SETTLE;
                  sel   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end

            ST_SETTLE: begin
               // Sample at the end of the window; Sel only moves on sampling edges.
               if (cnt == LAST) begin
                  data[sel] <= bus.F;
                  cnt       <= '0;
                  if (sel == 2'd3) begin
                     state <= ST_DONE;
                     valid <= 1'b1;
                  end else begin
                     sel <= sel + 2'd1;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end

            ST_DONE: begin
               if (bus.ready) begin
                  valid <= 1'b0;
                  sel   <= '0;
                  cnt   <= '0;
`ifdef MUX_SCAN_CONTINUOUS_EN
                  // Handshake edge opens the channel-0 window of the next scan.
                  state <= ST_SETTLE;
`else
                  state <= ST_IDLE;
                  busy  <= 1'b0;
`endif
               end
            end

            default: begin
               state <= ST_IDLE;
               sel   <= '0;
               cnt   <= '0;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Sel   = sel;
   assign bus.Data  = data;
   assign bus.valid = valid;
   assign bus.busy  = busy;

endmodule
